// File: rtl/hack_pkg.sv
// Shared types and widths for the Hack data-memory arbiter.
// The burst helper keeps the grant-limit comparison identical in every state that uses it.
package hack_pkg;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 16;
   localparam int BCNT_W = 4;

   typedef enum logic [1:0] {
      CPU_A,
      CPU_X,
      DMA_A,
      DMA_R
   } arb_state_t;

   // True while the DMA side may take another consecutive grant.
   function automatic logic burst_open(input logic [BCNT_W:0] granted, input int burst);
      return int'(granted) < burst;
   endfunction

endpackage

// File: rtl/hack_mem_arbiter_if.sv
// CPU, DMA and RAM bus bundle around the arbiter.
// The slave modport is the arbiter's view; master is the CPU/DMA/RAM environment's view.
interface hack_mem_arbiter_if
   import hack_pkg::*;
#(
   parameter int ADDR_W = hack_pkg::ADDR_W,
   parameter int DATA_W = hack_pkg::DATA_W
);

   logic [ADDR_W-1:0] cpu_addressM;
   logic              cpu_writeM;
   logic [DATA_W-1:0] cpu_outM;
   logic [DATA_W-1:0] cpu_inM;
   logic              cpu_en;

   logic              dma_valid;
   logic              dma_ready;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_rvalid;
   logic [DATA_W-1:0] dma_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_addressM, cpu_writeM, cpu_outM,
      input  dma_valid, dma_we, dma_addr, dma_wdata,
      input  mem_rdata,
      output cpu_inM, cpu_en,
      output dma_ready, dma_rvalid, dma_rdata,
      output mem_addr, mem_we, mem_wdata
   );

   modport master (
      output cpu_addressM, cpu_writeM, cpu_outM,
      output dma_valid, dma_we, dma_addr, dma_wdata,
      output mem_rdata,
      input  cpu_inM, cpu_en,
      input  dma_ready, dma_rvalid, dma_rdata,
      input  mem_addr, mem_we, mem_wdata
   );

endinterface

// File: rtl/hack_sync_ram.sv
// Single-port synchronous data RAM with a one-cycle registered read.
module hack_sync_ram
   import hack_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      rdata <= mem_q[addr];
   end

endmodule

// File: rtl/hack_mem_arbiter.sv
// Time-multiplexes the Hack CPU's two-cycle instruction and a DMA requester onto one RAM port.
// Outputs decode the current state; reset forces them quiet immediately, aborting any write.
module hack_mem_arbiter
   import hack_pkg::*;
#(
   parameter int DMA_BURST = 4
) (
   input  logic              clk_cpu,
   input  logic              rst,
   hack_mem_arbiter_if.slave bus
);

   arb_state_t        state_q, state_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic [BCNT_W:0]   bcnt_inc;

   logic              cpu_en;
   logic              dma_ready;
   logic              dma_rvalid;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   assign bcnt_inc = {1'b0, bcnt_q} + (BCNT_W+1)'(1);

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      case (state_q)
         CPU_A: state_d = CPU_X;
         CPU_X: begin
            bcnt_d  = '0;
            state_d = bus.dma_valid ? DMA_A : CPU_A;
         end
         DMA_A: begin
            bcnt_d = bcnt_inc[BCNT_W-1:0];
            if (!bus.dma_valid) begin
               state_d = CPU_A;
            end else if (!bus.dma_we) begin
               state_d = DMA_R;
            end else if (burst_open(bcnt_inc, DMA_BURST)) begin
               state_d = DMA_A;
            end else begin
               state_d = CPU_A;
            end
         end
         DMA_R: begin
            // bcnt already counts the read granted in the preceding DMA_A.
            if (bus.dma_valid && burst_open({1'b0, bcnt_q}, DMA_BURST)) begin
               state_d = DMA_A;
            end else begin
               state_d = CPU_A;
            end
         end
         default: state_d = CPU_A;
      endcase
   end

   always_comb begin
      cpu_en     = 1'b0;
      dma_ready  = 1'b0;
      dma_rvalid = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = bus.cpu_addressM;
      mem_wdata  = bus.cpu_outM;
      if (rst) begin
         mem_addr  = '0;
         mem_wdata = '0;
      end else begin
         case (state_q)
            CPU_X: begin
               cpu_en = 1'b1;
               mem_we = bus.cpu_writeM;
            end
            DMA_A: begin
               // A grant slot with no request present must not write stale data.
               dma_ready = 1'b1;
               mem_addr  = bus.dma_addr;
               mem_we    = bus.dma_valid & bus.dma_we;
               mem_wdata = bus.dma_wdata;
            end
            DMA_R:   dma_rvalid = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_cpu or posedge rst) begin
      if (rst) begin
         state_q <= CPU_A;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
      end
   end

   assign bus.cpu_en     = cpu_en;
   assign bus.dma_ready  = dma_ready;
   assign bus.dma_rvalid = dma_rvalid;
   assign bus.mem_we     = mem_we;
   assign bus.mem_addr   = mem_addr;
   assign bus.mem_wdata  = mem_wdata;
   assign bus.cpu_inM    = rst ? '0 : bus.mem_rdata;
   assign bus.dma_rdata  = rst ? '0 : bus.mem_rdata;

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Directed bench for hack_mem_arbiter with a scoreboard monitor on cpu_en and dma_rvalid.
module tb_hack_mem_arbiter;
   import hack_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] cpu_q [$];
   logic [DATA_W-1:0] dma_q [$];

   hack_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   hack_mem_arbiter #(.DMA_BURST(4)) dut (
      .clk_cpu (clk),
      .rst     (rst),
      .bus     (bus)
   );

   hack_sync_ram ram (
      .clk   (clk),
      .we    (bus.mem_we),
      .addr  (bus.mem_addr),
      .wdata (bus.mem_wdata),
      .rdata (bus.mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT presents CPU or DMA read data.
   initial begin
      logic [DATA_W-1:0] e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.cpu_en && cpu_q.size() > 0) begin
               e = cpu_q.pop_front();
               check("cpu_inM", 32'(bus.cpu_inM), 32'(e));
               $display("txn cpu_rd inM=%0d exp=%0d", bus.cpu_inM, e);
            end
            if (bus.dma_rvalid) begin
               if (dma_q.size() == 0) begin
                  check("dma_rvalid_spurious", 32'(bus.dma_rvalid), 32'd0);
               end else begin
                  e = dma_q.pop_front();
                  check("dma_rdata", 32'(bus.dma_rdata), 32'(e));
                  $display("txn dma_rd rdata=%0h exp=%0h", bus.dma_rdata, e);
               end
            end
         end
      end
   end

   // Returns just after the edge where the CPU commits an instruction.
   task automatic wait_commit();
      int n = 0;
      forever begin
         @(negedge clk);
         if (bus.cpu_en) break;
         n++;
         if (n > 50) begin
            check("cpu_en_timeout", 32'(bus.cpu_en), 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic dma_xfer(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input logic push_exp);
      int n = 0;
      bus.dma_valid = 1'b1;
      bus.dma_we    = we;
      bus.dma_addr  = addr;
      bus.dma_wdata = data;
      if (!we && push_exp) dma_q.push_back(data);
      forever begin
         @(negedge clk);
         if (bus.dma_ready) break;
         n++;
         if (n > 20) begin
            check("dma_ready_timeout", 32'(bus.dma_ready), 32'd1);
            break;
         end
      end
      check("dma_mem_addr", 32'(bus.mem_addr), 32'(addr));
      check("dma_mem_we", 32'(bus.mem_we), 32'(we));
      @(posedge clk);
      #1;
      bus.dma_valid = 1'b0;
      $display("txn dma_%s addr=%0d data=%0h", we ? "wr" : "rd", addr, data);
      if (!we) begin
         @(negedge clk);
         check("dma_rd_latency", 32'(bus.dma_rvalid), 32'd1);
      end
   endtask

   initial begin
      bus.cpu_addressM = 15'd100;
      bus.cpu_writeM   = 1'b0;
      bus.cpu_outM     = '0;
      bus.dma_valid    = 1'b0;
      bus.dma_we       = 1'b0;
      bus.dma_addr     = '0;
      bus.dma_wdata    = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
      check("rst_dma_ready", 32'(bus.dma_ready), 32'd0);
      check("rst_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
      check("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_cpu_inM", 32'(bus.cpu_inM), 32'd0);
      check("rst_dma_rdata", 32'(bus.dma_rdata), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Preload RAM through the DMA port
      dma_xfer(1'b1, 15'd100, 16'd11111, 1'b0);
      dma_xfer(1'b1, 15'd24576, 16'd77, 1'b0);

      // 1: CPU read with no DMA, cpu_en alternates
      wait_commit();
      cpu_q.push_back(16'd11111);
      cpu_q.push_back(16'd11111);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t1_cpu_en_toggle", 32'(bus.cpu_en), 32'(i % 2));
      end

      // 2: CPU write, single mem_we pulse in CPU_X
      @(posedge clk);
      #1;
      bus.cpu_addressM = 15'd1001;
      bus.cpu_outM     = 16'd1234;
      bus.cpu_writeM   = 1'b1;
      @(negedge clk);
      check("t2_we_cpu_a", 32'(bus.mem_we), 32'd0);
      @(negedge clk);
      check("t2_we_cpu_x", 32'(bus.mem_we), 32'd1);
      check("t2_addr_cpu_x", 32'(bus.mem_addr), 32'd1001);
      check("t2_wdata_cpu_x", 32'(bus.mem_wdata), 32'd1234);
      @(posedge clk);
      #1;
      bus.cpu_writeM = 1'b0;
      cpu_q.push_back(16'd1234);
      @(negedge clk);
      check("t2_we_after", 32'(bus.mem_we), 32'd0);
      @(negedge clk);
      check("t2_readback_en", 32'(bus.cpu_en), 32'd1);

      // 3: DMA write ordering CPU_A, CPU_X, DMA_A
      @(posedge clk);
      #1;
      bus.cpu_addressM = 15'd100;
      bus.dma_valid = 1'b1;
      bus.dma_we    = 1'b1;
      bus.dma_addr  = 15'd16384;
      bus.dma_wdata = 16'hFFFF;
      @(negedge clk);
      check("t3_cpu_a_en", 32'(bus.cpu_en), 32'd0);
      check("t3_cpu_a_ready", 32'(bus.dma_ready), 32'd0);
      @(negedge clk);
      check("t3_cpu_x_en", 32'(bus.cpu_en), 32'd1);
      check("t3_cpu_x_ready", 32'(bus.dma_ready), 32'd0);
      @(negedge clk);
      check("t3_dma_a_ready", 32'(bus.dma_ready), 32'd1);
      check("t3_dma_a_we", 32'(bus.mem_we), 32'd1);
      check("t3_dma_a_addr", 32'(bus.mem_addr), 32'd16384);
      @(posedge clk);
      #1;
      bus.dma_valid = 1'b0;
      $display("txn dma_wr addr=16384 data=ffff");
      wait_commit();
      dma_xfer(1'b0, 15'd16384, 16'hFFFF, 1'b1);

      // 4: DMA read, then back to CPU_A
      wait_commit();
      dma_xfer(1'b0, 15'd24576, 16'd77, 1'b1);
      @(negedge clk);
      check("t4_after_rvalid", 32'(bus.dma_rvalid), 32'd0);
      check("t4_after_ready", 32'(bus.dma_ready), 32'd0);
      check("t4_after_cpu_en", 32'(bus.cpu_en), 32'd0);
      check("t4_after_addr", 32'(bus.mem_addr), 32'd100);

      // 5: saturated DMA writes, burst of 4 then one CPU instruction
      wait_commit();
      bus.dma_valid = 1'b1;
      bus.dma_we    = 1'b1;
      bus.dma_addr  = 15'd200;
      bus.dma_wdata = 16'd5;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         check("t5_ready", 32'(bus.dma_ready), 32'((i % 6) >= 2));
         check("t5_cpu_en", 32'(bus.cpu_en), 32'((i % 6) == 1));
      end
      @(posedge clk);
      #1;
      bus.dma_valid = 1'b0;
      $display("txn dma_burst 12 writes addr=200");

      // 6: reset during DMA_R
      wait_commit();
      bus.dma_valid = 1'b1;
      bus.dma_we    = 1'b0;
      bus.dma_addr  = 15'd24576;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.dma_ready) break;
      end
      check("t6_ready_seen", 32'(bus.dma_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.dma_valid = 1'b0;
      check("t6_in_dma_r", 32'(bus.dma_rvalid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_rvalid", 32'(bus.dma_rvalid), 32'd0);
      check("t6_rst_mem_we", 32'(bus.mem_we), 32'd0);
      check("t6_rst_cpu_en", 32'(bus.cpu_en), 32'd0);
      check("t6_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      $display("txn rst_during_dma_r");
      @(negedge clk);
      check("t6_rel_cpu_en0", 32'(bus.cpu_en), 32'd0);
      check("t6_rel_rvalid0", 32'(bus.dma_rvalid), 32'd0);
      @(negedge clk);
      check("t6_rel_cpu_en1", 32'(bus.cpu_en), 32'd1);
      check("t6_rel_rvalid1", 32'(bus.dma_rvalid), 32'd0);
      repeat (4) @(negedge clk);

      check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
      check("dma_q_drained", 32'(dma_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
